// File: rtl/axil_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one command into a full write
// (AW+W, then B) or read (AR, then R) transaction and returns the response.
module axil_master_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic                      CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]     CMD_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   CMD_WSTRB,
    output logic                      RSP_VALID,
    output logic [DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                RSP_RESP,
    output logic [ADDR_WIDTH-1:0]     M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    aw_left;
    logic                    w_left;

    // Ready is gated by reset so it reads 0 during reset and 1 right after release.
    assign CMD_READY = (state == IDLE) && !ARESET;
    assign M_AWADDR  = addr_q;
    assign M_ARADDR  = addr_q;

    // A request channel is still pending after this edge unless it handshakes now.
    assign aw_left = M_AWVALID && !M_AWREADY;
    assign w_left  = M_WVALID && !M_WREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            addr_q    <= '0;
            M_WDATA   <= '0;
            M_WSTRB   <= '0;
            M_AWVALID <= 1'b0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_RESP  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        addr_q  <= CMD_ADDR;
                        M_WDATA <= CMD_WDATA;
                        M_WSTRB <= CMD_WSTRB;
                        if (CMD_WRITE) begin
                            M_AWVALID <= 1'b1;
                            M_WVALID  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            M_ARVALID <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    M_AWVALID <= aw_left;
                    M_WVALID  <= w_left;
                    if (!aw_left && !w_left) begin
                        M_BREADY <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_BVALID) begin
                        M_BREADY  <= 1'b0;
                        RSP_RESP  <= M_BRESP;
                        RSP_RDATA <= '0;
                        RSP_VALID <= 1'b1;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_RVALID) begin
                        M_RREADY  <= 1'b0;
                        RSP_RESP  <= M_RRESP;
                        RSP_RDATA <= M_RDATA;
                        RSP_VALID <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    RSP_VALID <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
